// File: rtl/decode_execute_pipe.sv
// ID/EX pipeline register with E-stage hazard unit.
// Captures decode-stage operands and control into the execute stage. It also
// detects load-use stalls, flushes on taken branches, selects M/W forwarding,
// and keeps a saturating count of load-use stall cycles.
module decode_execute_pipe #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    RD1D,
  input  logic [DATA_WIDTH-1:0]    RD2D,
  input  logic [ADDRESS_WIDTH-1:0] rs1D,
  input  logic [ADDRESS_WIDTH-1:0] rs2D,
  input  logic [ADDRESS_WIDTH-1:0] rdD,
  input  logic [DATA_WIDTH-1:0]    ImmExtD,
  input  logic [DATA_WIDTH-1:0]    PCD,
  input  logic [DATA_WIDTH-1:0]    PCPlus4D,
  input  logic                     RegWriteD,
  input  logic                     MemWriteD,
  input  logic                     JumpD,
  input  logic                     BranchD,
  input  logic                     ALUSrcD,
  input  logic [1:0]               ResultSrcD,
  input  logic [2:0]               ALUControlD,
  input  logic                     PCSrcE,
  input  logic [ADDRESS_WIDTH-1:0] rdM,
  input  logic [ADDRESS_WIDTH-1:0] rdW,
  input  logic                     RegWriteM,
  input  logic                     RegWriteW,
  output logic [DATA_WIDTH-1:0]    RD1E,
  output logic [DATA_WIDTH-1:0]    RD2E,
  output logic [ADDRESS_WIDTH-1:0] rs1E,
  output logic [ADDRESS_WIDTH-1:0] rs2E,
  output logic [ADDRESS_WIDTH-1:0] rdE,
  output logic [DATA_WIDTH-1:0]    ImmExtE,
  output logic [DATA_WIDTH-1:0]    PCE,
  output logic [DATA_WIDTH-1:0]    PCPlus4E,
  output logic                     RegWriteE,
  output logic                     MemWriteE,
  output logic                     JumpE,
  output logic                     BranchE,
  output logic                     ALUSrcE,
  output logic [1:0]               ResultSrcE,
  output logic [2:0]               ALUControlE,
  output logic                     StallF,
  output logic                     StallD,
  output logic                     FlushD,
  output logic [1:0]               ForwardAE,
  output logic [1:0]               ForwardBE,
  output logic [CNT_WIDTH-1:0]     StallCnt
);

  logic                     w_lwStall;
  logic                     w_flushE;
  logic [CNT_WIDTH-1:0]     r_stallCnt;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Forward select for one E operand; M is newer than W so it wins. x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [ADDRESS_WIDTH-1:0] rsE,
                                         input logic [ADDRESS_WIDTH-1:0] dM,
                                         input logic                     weM,
                                         input logic [ADDRESS_WIDTH-1:0] dW,
                                         input logic                     weW);
    if (weM && (dM != '0) && (dM == rsE)) return 2'b10;
    if (weW && (dW != '0) && (dW == rsE)) return 2'b01;
    return 2'b00;
  endfunction

  // Hazard detection: a load in E whose destination feeds the instruction in D.
  always_comb begin
    w_lwStall = (ResultSrcE == 2'b01) && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
    w_flushE  = w_lwStall || PCSrcE;
    StallF    = w_lwStall && !PCSrcE;
    StallD    = w_lwStall && !PCSrcE;
    FlushD    = PCSrcE;
    ForwardAE = fwd_sel(rs1E, rdM, RegWriteM, rdW, RegWriteW);
    ForwardBE = fwd_sel(rs2E, rdM, RegWriteM, rdW, RegWriteW);
  end

  // ---- D -> E stage boundary: bubble on flush, otherwise copy every D field ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_flushE) begin
      RD1E        <= '0;
      RD2E        <= '0;
      rs1E        <= '0;
      rs2E        <= '0;
      rdE         <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 3'b000;
    end else begin
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      rs1E        <= rs1D;
      rs2E        <= rs2D;
      rdE         <= rdD;
      ImmExtE     <= ImmExtD;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      RegWriteE   <= RegWriteD;
      MemWriteE   <= MemWriteD;
      JumpE       <= JumpD;
      BranchE     <= BranchD;
      ALUSrcE     <= ALUSrcD;
      ResultSrcE  <= ResultSrcD;
      ALUControlE <= ALUControlD;
    end
  end

  // Performance counter: one tick per cycle the decode stage is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_stallCnt <= '0;
    else if (StallD) r_stallCnt <= sat_inc(r_stallCnt);
  end

  assign StallCnt = r_stallCnt;

endmodule

// File: tb/tb_decode_execute_pipe.sv
// Bench for decode_execute_pipe: directed vectors with literal expectations,
// plus a per-cycle comparison against a behavioural E-stage model.
module tb_decode_execute_pipe;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] RD1D = '0, RD2D = '0, ImmExtD = '0, PCD = '0, PCPlus4D = '0;
  logic [AW-1:0] rs1D = '0, rs2D = '0, rdD = '0, rdM = '0, rdW = '0;
  logic RegWriteD = 0, MemWriteD = 0, JumpD = 0, BranchD = 0, ALUSrcD = 0;
  logic [1:0] ResultSrcD = '0;
  logic [2:0] ALUControlD = '0;
  logic PCSrcE = 0, RegWriteM = 0, RegWriteW = 0;

  logic [DW-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [AW-1:0] rs1E, rs2E, rdE;
  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0] ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0] ALUControlE;
  logic StallF, StallD, FlushD;
  logic [15:0] StallCnt;

  // Second instance with a 4-bit counter for the saturation check.
  logic [DW-1:0] s_RD1E, s_RD2E, s_ImmExtE, s_PCE, s_PCPlus4E;
  logic [AW-1:0] s_rs1E, s_rs2E, s_rdE;
  logic s_RegWriteE, s_MemWriteE, s_JumpE, s_BranchE, s_ALUSrcE;
  logic [1:0] s_ResultSrcE, s_ForwardAE, s_ForwardBE;
  logic [2:0] s_ALUControlE;
  logic s_StallF, s_StallD, s_FlushD;
  logic [3:0] s_StallCnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_execute_pipe #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .RD1D(RD1D), .RD2D(RD2D), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D), .RegWriteD(RegWriteD),
    .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .PCSrcE(PCSrcE), .rdM(rdM),
    .rdW(rdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .RD1E(RD1E), .RD2E(RD2E),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .StallCnt(StallCnt));

  decode_execute_pipe #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .RD1D(RD1D), .RD2D(RD2D), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D), .RegWriteD(RegWriteD),
    .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .PCSrcE(PCSrcE), .rdM(rdM),
    .rdW(rdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .RD1E(s_RD1E), .RD2E(s_RD2E),
    .rs1E(s_rs1E), .rs2E(s_rs2E), .rdE(s_rdE), .ImmExtE(s_ImmExtE), .PCE(s_PCE),
    .PCPlus4E(s_PCPlus4E), .RegWriteE(s_RegWriteE), .MemWriteE(s_MemWriteE),
    .JumpE(s_JumpE), .BranchE(s_BranchE), .ALUSrcE(s_ALUSrcE), .ResultSrcE(s_ResultSrcE),
    .ALUControlE(s_ALUControlE), .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD),
    .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE), .StallCnt(s_StallCnt));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [DW-1:0] rd1, rd2, imm, pc, pc4;
    logic [AW-1:0] rs1, rs2, rd;
    logic rw, mw, j, b, as;
    logic [1:0] rsrc;
    logic [2:0] alu;
  } e_t;

  e_t m_e;
  int m_stalls;

  function automatic logic m_loaduse(input e_t e, input logic [AW-1:0] a, input logic [AW-1:0] b);
    return e.rsrc == 2'd1 && e.rd != 0 && (e.rd == a || e.rd == b);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] src);
    if (src == 0) return 2'd0;
    if (RegWriteM && rdM == src) return 2'd2;
    if (RegWriteW && rdW == src) return 2'd1;
    return 2'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_e <= '0;
      m_stalls <= 0;
    end else if (m_loaduse(m_e, rs1D, rs2D) || PCSrcE) begin
      if (!PCSrcE) m_stalls <= m_stalls + 1;
      m_e <= '0;
    end else begin
      m_e <= '{RD1D, RD2D, ImmExtD, PCD, PCPlus4D, rs1D, rs2D, rdD,
               RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD};
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic st;
    st = m_loaduse(m_e, rs1D, rs2D) && !PCSrcE;
    chk("m_RD1E", RD1E, m_e.rd1);
    chk("m_RD2E", RD2E, m_e.rd2);
    chk("m_ImmExtE", ImmExtE, m_e.imm);
    chk("m_PCE", PCE, m_e.pc);
    chk("m_PCPlus4E", PCPlus4E, m_e.pc4);
    chk("m_regsE", {rs1E, rs2E, rdE}, {m_e.rs1, m_e.rs2, m_e.rd});
    chk("m_ctrlE", {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE},
        {m_e.rw, m_e.mw, m_e.j, m_e.b, m_e.as, m_e.rsrc, m_e.alu});
    chk("m_hazard", {StallF, StallD, FlushD}, {st, st, PCSrcE});
    chk("m_fwd", {ForwardAE, ForwardBE}, {m_fwd(m_e.rs1), m_fwd(m_e.rs2)});
    chk("m_cnt", StallCnt, (m_stalls > 65535) ? 65535 : m_stalls);
    chk("m_cnt4", s_StallCnt, (m_stalls > 15) ? 15 : m_stalls);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drive_lw(input logic [AW-1:0] rd);
    ResultSrcD = 2'b01; RegWriteD = 1; MemWriteD = 0; rdD = rd; rs1D = 5'd1; rs2D = 5'd2;
  endtask

  task automatic drive_alu(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d);
    ResultSrcD = 2'b00; RegWriteD = 1; MemWriteD = 0; rs1D = a; rs2D = b; rdD = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random D inputs
    RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom; PCPlus4D = $urandom;
    rs1D = 5'($urandom); rs2D = 5'($urandom); rdD = 5'($urandom);
    RegWriteD = 1; MemWriteD = 1; JumpD = 1; BranchD = 1; ResultSrcD = 2'b01;
    step(); step();
    @(negedge clk);
    chk("rst_RD1E", RD1E, 0);
    chk("rst_ctrl", {RegWriteE, MemWriteE, JumpE, BranchE, rdE}, 0);
    chk("rst_cnt", StallCnt, 0);
    chk("rst_stall", {StallF, StallD, FlushD}, 0);
    rst = 0;
    RD1D = 32'hDEADBEEF; PCD = 32'h0000_0040; rdD = 5'd3; rs1D = 5'd4; rs2D = 5'd6;
    ResultSrcD = 2'b00; JumpD = 0; BranchD = 0; MemWriteD = 0; ALUControlD = 3'd5;
    step();
    @(negedge clk);
    chk("cap_RD1E", RD1E, 32'hDEADBEEF);
    chk("cap_PCE", PCE, 32'h40);
    chk("cap_rdE", rdE, 3);
    chk("cap_alu", ALUControlE, 5);

    // Load-use on rs1
    do_reset();
    drive_lw(5'd5);
    step();
    drive_alu(5'd5, 5'd8, 5'd6);
    @(negedge clk);
    chk("lu_stall", {StallF, StallD, FlushD}, 3'b110);
    step();
    @(negedge clk);
    chk("lu_bubble", {RegWriteE, ResultSrcE, rdE}, 0);
    chk("lu_nostall", StallD, 0);
    chk("lu_cnt", StallCnt, 1);
    step();
    @(negedge clk);
    chk("lu_recap", {rs1E, rdE}, {5'd5, 5'd6});

    // Load into x0 never stalls
    drive_lw(5'd0);
    step();
    drive_alu(5'd0, 5'd0, 5'd9);
    PCD = 32'h100;
    @(negedge clk);
    chk("x0_nostall", StallD, 0);
    step();
    @(negedge clk);
    chk("x0_cap", {rdE, PCE}, {5'd9, 32'h100});
    chk("x0_cnt", StallCnt, 1);

    // Forwarding priority
    drive_alu(5'd7, 5'd3, 5'd10);
    step();
    rdM = 5'd7; RegWriteM = 1; rdW = 5'd7; RegWriteW = 1;
    #1;
    chk("fwd_M", {ForwardAE, ForwardBE}, {2'b10, 2'b00});
    RegWriteM = 0;
    #1;
    chk("fwd_W", ForwardAE, 2'b01);
    rdW = 5'd0;
    #1;
    chk("fwd_none", ForwardAE, 2'b00);
    rdM = 5'd3; RegWriteM = 1; rdW = 5'd3; RegWriteW = 1;
    #1;
    chk("fwd_B_M", {ForwardAE, ForwardBE}, {2'b00, 2'b10});
    rdM = 0; rdW = 0; RegWriteM = 0; RegWriteW = 0;

    // Branch flush
    drive_alu(5'd1, 5'd2, 5'd12);
    MemWriteD = 1;
    PCSrcE = 1;
    #1;
    chk("br_flushD", {FlushD, StallD}, 2'b10);
    step();
    PCSrcE = 0;
    MemWriteD = 0;
    @(negedge clk);
    chk("br_bubble", {RegWriteE, MemWriteE, rdE}, 0);

    // Load-use coinciding with a flush: flush wins, no count
    drive_lw(5'd5);
    step();
    drive_alu(5'd5, 5'd5, 5'd2);
    PCSrcE = 1;
    #1;
    chk("lubr_stall", {StallF, StallD, FlushD}, 3'b001);
    step();
    PCSrcE = 0;
    @(negedge clk);
    chk("lubr_bubble", {RegWriteE, ResultSrcE, rdE}, 0);
    chk("lubr_cnt", StallCnt, 1);

    // Reset in the middle of a stall
    drive_lw(5'd5);
    step();
    drive_alu(5'd5, 5'd1, 5'd4);
    @(negedge clk);
    chk("rs_stall", StallD, 1);
    #1 rst = 1;
    #1;
    chk("rs_clear", {StallF, StallD, rdE}, 0);
    chk("rs_cnt", StallCnt, 0);
    step();
    rst = 0;

    // Saturation: 20 load-use events
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive_lw(5'd5);
      step();
      drive_alu(5'd5, 5'd2, 5'd7);
      step();
    end
    @(negedge clk);
    chk("sat_cnt4", s_StallCnt, 15);
    chk("sat_cnt16", StallCnt, 20);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
